// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter in front of a single 32-bit memory port.
// The memory is given a fixed access latency and each port gets a one-cycle ack pulse when its access finishes.
module mem_bus_arbiter #(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        rw0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic [31:0] rdata0,
  output logic        ack0,
  input  logic        req1,
  input  logic        rw1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic [31:0] rdata1,
  output logic        ack1,
  output logic        mem_en,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        owner,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             rr, rr_nx;
  logic             owner_nx;
  logic             gnt;
  logic             lat_rw, lat_rw_nx;
  logic [31:0]      lat_addr, lat_addr_nx;
  logic [31:0]      lat_wdata, lat_wdata_nx;
  logic [31:0]      rdata0_nx, rdata1_nx;
  logic             access_nx;

  // Next-state, latch and capture logic for the arbitration FSM
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    rr_nx        = rr;
    owner_nx     = owner;
    gnt          = 1'b0;
    lat_rw_nx    = lat_rw;
    lat_addr_nx  = lat_addr;
    lat_wdata_nx = lat_wdata;
    rdata0_nx    = rdata0;
    rdata1_nx    = rdata1;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          // a lone requester wins outright; rr only breaks ties
          gnt          = (req0 && req1) ? rr : req1;
          lat_rw_nx    = gnt ? rw1    : rw0;
          lat_addr_nx  = gnt ? addr1  : addr0;
          lat_wdata_nx = gnt ? wdata1 : wdata0;
          owner_nx     = gnt;
          rr_nx        = ~gnt;
          cnt_nx       = CNT_W'(LATENCY);
          state_nx     = ACCESS;
        end else begin
          state_nx = IDLE;
        end
      end
      ACCESS: begin
        if (cnt != {CNT_W{1'b0}}) begin
          cnt_nx = cnt - CNT_W'(1);
        end else begin
          if (lat_rw) begin
            if (owner) begin
              rdata1_nx = mem_rdata;
            end else begin
              rdata0_nx = mem_rdata;
            end
          end else begin
            rdata0_nx = rdata0;
          end
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign access_nx = (state_nx == ACCESS);

  // State, latched request and registered outputs derived from the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= {CNT_W{1'b0}};
      rr        <= 1'b0;
      owner     <= 1'b0;
      lat_rw    <= 1'b0;
      lat_addr  <= 32'h0000_0000;
      lat_wdata <= 32'h0000_0000;
      rdata0    <= 32'h0000_0000;
      rdata1    <= 32'h0000_0000;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      mem_en    <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      rr        <= rr_nx;
      owner     <= owner_nx;
      lat_rw    <= lat_rw_nx;
      lat_addr  <= lat_addr_nx;
      lat_wdata <= lat_wdata_nx;
      rdata0    <= rdata0_nx;
      rdata1    <= rdata1_nx;
      ack0      <= (state_nx == DONE) && !owner_nx;
      ack1      <= (state_nx == DONE) && owner_nx;
      mem_en    <= access_nx;
      mem_rw    <= access_nx && lat_rw_nx;
      mem_addr  <= access_nx ? lat_addr_nx : 32'h0000_0000;
      mem_wdata <= (access_nx && !lat_rw_nx) ? lat_wdata_nx : 32'h0000_0000;
      busy      <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter: one LATENCY=1 instance
// and one LATENCY=0 instance, with hand-computed expectations.
module tb_mem_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        req0 = 1'b0, rw0 = 1'b0, req1 = 1'b0, rw1 = 1'b0;
  logic [31:0] addr0 = 32'h0, wdata0 = 32'h0, addr1 = 32'h0, wdata1 = 32'h0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
  logic        ack0, ack1, mem_en, mem_rw, owner, busy;

  logic        z_req0 = 1'b0, z_rw0 = 1'b0;
  logic [31:0] z_addr0 = 32'h0, z_mem_rdata = 32'h0;
  logic [31:0] z_rdata0, z_rdata1, z_mem_addr, z_mem_wdata;
  logic        z_ack0, z_ack1, z_mem_en, z_mem_rw, z_owner, z_busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_bus_arbiter #(.LATENCY(1), .CNT_W(4)) u_dut (
    .clock(clock), .reset(reset),
    .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0), .ack0(ack0),
    .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1), .ack1(ack1),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
  );

  mem_bus_arbiter #(.LATENCY(0), .CNT_W(4)) u_lat0 (
    .clock(clock), .reset(reset),
    .req0(z_req0), .rw0(z_rw0), .addr0(z_addr0), .wdata0(32'h0), .rdata0(z_rdata0), .ack0(z_ack0),
    .req1(1'b0), .rw1(1'b0), .addr1(32'h0), .wdata1(32'h0), .rdata1(z_rdata1), .ack1(z_ack1),
    .mem_en(z_mem_en), .mem_rw(z_mem_rw), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
    .mem_rdata(z_mem_rdata), .owner(z_owner), .busy(z_busy)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset held two cycles, then ten idle cycles
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_ctrl", {26'h0, mem_en, mem_rw, ack0, ack1, owner, busy}, 32'h0);
      check("idle_bus", mem_addr | mem_wdata | rdata0 | rdata1, 32'h0);
    end

    // single read from port 0, LATENCY=1
    mem_rdata = 32'hDEAD_BEEF;
    req0 = 1'b1; rw0 = 1'b1; addr0 = 32'h10;
    tick();
    check("rd_acc1_en", {31'h0, mem_en}, 32'h1);
    check("rd_acc1_addr", mem_addr, 32'h10);
    check("rd_acc1_rw", {31'h0, mem_rw}, 32'h1);
    check("rd_acc1_busy", {30'h0, busy, ack0}, 32'h2);
    tick();
    check("rd_acc2_en", {31'h0, mem_en}, 32'h1);
    check("rd_acc2_addr", mem_addr, 32'h10);
    check("rd_acc2_ack", {30'h0, ack0, ack1}, 32'h0);
    tick();
    check("rd_done_ack", {29'h0, ack0, ack1, mem_en}, 32'h4);
    check("rd_done_data", rdata0, 32'hDEAD_BEEF);
    check("rd_done_busy", {31'h0, busy}, 32'h1);
    req0 = 1'b0;
    tick();
    check("rd_idle", {29'h0, ack0, busy, mem_en}, 32'h0);
    check("rd_hold", rdata0, 32'hDEAD_BEEF);

    // single write from port 1
    mem_rdata = 32'hCAFE_F00D;
    req1 = 1'b1; rw1 = 1'b0; addr1 = 32'h20; wdata1 = 32'h1234_5678;
    tick();
    check("wr_acc1_ctrl", {29'h0, mem_en, mem_rw, owner}, 32'h5);
    check("wr_acc1_addr", mem_addr, 32'h20);
    check("wr_acc1_wdata", mem_wdata, 32'h1234_5678);
    tick();
    check("wr_acc2_wdata", mem_wdata, 32'h1234_5678);
    tick();
    check("wr_done_ack", {29'h0, ack0, ack1, mem_en}, 32'h2);
    check("wr_done_rdata1", rdata1, 32'h0);
    check("wr_done_rdata0", rdata0, 32'hDEAD_BEEF);
    check("wr_done_wdata", mem_wdata, 32'h0);
    req1 = 1'b0;
    tick();
    check("wr_idle", {30'h0, ack1, busy}, 32'h0);

    // both ports requesting continuously from reset: grants 0,1,0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rr_reset_rdata", rdata0 | rdata1, 32'h0);
    mem_rdata = 32'h55AA_55AA;
    req0 = 1'b1; rw0 = 1'b1; addr0 = 32'h100;
    req1 = 1'b1; rw1 = 1'b1; addr1 = 32'h200;
    for (int k = 1; k <= 12; k++) begin
      int phase;
      int port;
      logic [31:0] exp_addr;
      tick();
      phase = (k - 1) % 4;
      port  = ((k - 1) / 4) % 2;
      exp_addr = (phase < 2) ? ((port == 1) ? 32'h200 : 32'h100) : 32'h0;
      check("rr_owner", {31'h0, owner}, port[31:0]);
      check("rr_en_busy", {30'h0, mem_en, busy}, {30'h0, phase < 2, phase < 3});
      check("rr_addr", mem_addr, exp_addr);
      check("rr_acks", {30'h0, ack0, ack1},
            {30'h0, (phase == 2) && (port == 0), (phase == 2) && (port == 1)});
    end
    check("rr_rdata0", rdata0, 32'h55AA_55AA);
    check("rr_rdata1", rdata1, 32'h55AA_55AA);
    req0 = 1'b0; req1 = 1'b0;

    // reset asserted in the second ACCESS cycle of a port-0 read
    mem_rdata = 32'h7777_0000;
    req0 = 1'b1; rw0 = 1'b1; addr0 = 32'h40;
    tick();
    check("rst_acc1", {31'h0, mem_en}, 32'h1);
    tick();
    check("rst_acc2_addr", mem_addr, 32'h40);
    reset = 1'b1;
    req0 = 1'b0;
    tick();
    check("rst_ctrl", {27'h0, mem_en, ack0, ack1, busy, owner}, 32'h0);
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    tick();
    check("rst_noack", {30'h0, ack0, ack1}, 32'h0);
    reset = 1'b0;

    // LATENCY=0 instance: single ACCESS cycle, ack at t+2
    z_mem_rdata = 32'h0BAD_F00D;
    z_req0 = 1'b1; z_rw0 = 1'b1; z_addr0 = 32'h4;
    tick();
    check("l0_acc_en", {30'h0, z_mem_en, z_ack0}, 32'h2);
    check("l0_acc_addr", z_mem_addr, 32'h4);
    tick();
    check("l0_done", {29'h0, z_mem_en, z_ack0, z_busy}, 32'h3);
    check("l0_rdata", z_rdata0, 32'h0BAD_F00D);
    z_req0 = 1'b0;
    tick();
    check("l0_idle", {29'h0, z_ack0, z_ack1, z_busy}, 32'h0);
    check("l0_hold", z_rdata0, 32'h0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
